// File: rtl/sel_fetch.sv
// Command-fetch sequencer: reads the word at the start-register address, hands ordinary
// commands to the PU and resolves jump/halt itself by steering the start register.
module sel_fetch #(
    parameter int         WORD_W  = 36,
    parameter logic [5:0] OP_JMP  = 6'o16,
    parameter logic [5:0] OP_JCND = 6'o17,
    parameter logic [5:0] OP_HALT = 6'o77
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_from_pnl,
    input  logic              stop_from_pnl,
    input  logic              step_from_pnl,
    input  logic [11:0]       strt_value_from_strt,
    output logic              mem_rd_req_to_mem,
    output logic [11:0]       mem_addr_to_mem,
    input  logic              mem_rd_ack_from_mem,
    input  logic [WORD_W-1:0] mem_data_from_mem,
    output logic              cmd_valid_to_pu,
    output logic [WORD_W-1:0] cmd_word_to_pu,
    input  logic              cmd_done_from_pu,
    input  logic              cond_from_ar,
    output logic              do_inc_strt_to_strt,
    output logic              do_sel_to_strt_to_strt,
    output logic [11:0]       sel_value_to_strt,
    output logic              running_to_pnl,
    output logic              halted_to_pnl
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, ADV} state_t;

    state_t     state;
    logic       addr_pend;
    logic       stop_pend;
    logic [5:0] opcode;

    assign opcode            = mem_data_from_mem[WORD_W-1 -: 6];
    assign sel_value_to_strt = cmd_word_to_pu[11:0];
    assign running_to_pnl    = (state != IDLE);

    // addr_pend marks the first FETCH cycle after ADV, when the start register is still updating.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state                  <= IDLE;
            addr_pend              <= 1'b0;
            stop_pend              <= 1'b0;
            halted_to_pnl          <= 1'b0;
            mem_rd_req_to_mem      <= 1'b0;
            mem_addr_to_mem        <= 12'd0;
            cmd_valid_to_pu        <= 1'b0;
            cmd_word_to_pu         <= '0;
            do_inc_strt_to_strt    <= 1'b0;
            do_sel_to_strt_to_strt <= 1'b0;
        end else begin
            do_inc_strt_to_strt    <= 1'b0;
            do_sel_to_strt_to_strt <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_from_pnl && !stop_from_pnl) begin
                        state             <= FETCH;
                        mem_addr_to_mem   <= strt_value_from_strt;
                        mem_rd_req_to_mem <= 1'b1;
                        addr_pend         <= 1'b0;
                        halted_to_pnl     <= 1'b0;
                        stop_pend         <= 1'b0;
                    end
                end
                FETCH: begin
                    if (stop_from_pnl) stop_pend <= 1'b1;
                    if (addr_pend) begin
                        addr_pend         <= 1'b0;
                        mem_addr_to_mem   <= strt_value_from_strt;
                        mem_rd_req_to_mem <= 1'b1;
                    end else if (mem_rd_ack_from_mem) begin
                        mem_rd_req_to_mem <= 1'b0;
                        cmd_word_to_pu    <= mem_data_from_mem;
                        if (opcode == OP_HALT) begin
                            state         <= IDLE;
                            halted_to_pnl <= 1'b1;
                            stop_pend     <= 1'b0;
                        end else if (opcode == OP_JMP || (opcode == OP_JCND && cond_from_ar)) begin
                            state                  <= ADV;
                            do_sel_to_strt_to_strt <= 1'b1;
                        end else if (opcode == OP_JCND) begin
                            state               <= ADV;
                            do_inc_strt_to_strt <= 1'b1;
                        end else begin
                            state           <= EXEC;
                            cmd_valid_to_pu <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (stop_from_pnl) stop_pend <= 1'b1;
                    if (cmd_done_from_pu) begin
                        state               <= ADV;
                        cmd_valid_to_pu     <= 1'b0;
                        do_inc_strt_to_strt <= 1'b1;
                    end
                end
                ADV: begin
                    if (stop_pend || step_from_pnl || stop_from_pnl) begin
                        state     <= IDLE;
                        stop_pend <= 1'b0;
                    end else begin
                        state     <= FETCH;
                        addr_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sel_fetch.sv
// Bench for sel_fetch: memory, PU and start register are modelled around the DUT and
// every cycle is compared against an event-schedule model of the fetch/execute sequence.
module tb_sel_fetch;
    localparam int         WORD_W  = 36;
    localparam logic [5:0] OP_JMP  = 6'o16;
    localparam logic [5:0] OP_JCND = 6'o17;
    localparam logic [5:0] OP_HALT = 6'o77;

    logic clk = 1'b0;
    logic resetn, start, stop, step, ack, done, cond;
    logic [11:0] strt;
    logic [WORD_W-1:0] data;
    logic req, valid, inc, sel, running, halted;
    logic [11:0] addr, sel_value;
    logic [WORD_W-1:0] word;

    sel_fetch #(.WORD_W(WORD_W), .OP_JMP(OP_JMP), .OP_JCND(OP_JCND), .OP_HALT(OP_HALT)) dut (
        .clk(clk), .resetn(resetn),
        .start_from_pnl(start), .stop_from_pnl(stop), .step_from_pnl(step),
        .strt_value_from_strt(strt),
        .mem_rd_req_to_mem(req), .mem_addr_to_mem(addr),
        .mem_rd_ack_from_mem(ack), .mem_data_from_mem(data),
        .cmd_valid_to_pu(valid), .cmd_word_to_pu(word), .cmd_done_from_pu(done),
        .cond_from_ar(cond),
        .do_inc_strt_to_strt(inc), .do_sel_to_strt_to_strt(sel), .sel_value_to_strt(sel_value),
        .running_to_pnl(running), .halted_to_pnl(halted)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] mem [4096];
    bit cond_tbl [4096];
    bit rand_cond, spurious_done, force_ack;
    logic [WORD_W-1:0] force_data;
    int mem_wait_cfg, pu_wait_cfg, mem_wait, pu_wait, mem_cnt, pu_cnt;

    // Reference model: when the next fetch and the next strobe are due, and what they must carry.
    int cyc, fetch_due, adv_cycle, adv_kind;
    bit m_running, m_halted, m_req, m_valid, stop_flag;
    logic [11:0] exp_addr, adv_target;
    logic [WORD_W-1:0] m_word;

    int inc_count, sel_count, valid_cycles, req_cycles, fetch_count, last_ack, prev_ack;
    logic [11:0] first_fetch_addr, last_fetch_addr, last_sel_value;
    bit req_prev;

    int checks, passed;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    function automatic int pickWait(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    function automatic logic [WORD_W-1:0] randWord();
        int r;
        logic [5:0] op;
        r = int'($urandom_range(0, 15));
        if (r == 0) op = OP_HALT;
        else if (r < 4) op = OP_JMP;
        else if (r < 7) op = OP_JCND;
        else op = 6'($urandom_range(0, 13));
        return {op, 18'($urandom), 12'($urandom)};
    endfunction

    // One clock cycle: compare outputs with the model, answer as memory/PU, advance the model.
    task automatic applyStimulus();
        logic [5:0] op;
        logic [11:0] strt_next;
        bit cur_valid, adv_now;
        @(negedge clk);
        if (cyc == fetch_due) m_req = 1'b1;
        adv_now = (cyc == adv_cycle);
        checkOutput("running", 64'(running), 64'(m_running));
        checkOutput("halted", 64'(halted), 64'(m_halted));
        checkOutput("req", 64'(req), 64'(m_req));
        if (m_req) checkOutput("fetch_addr", 64'(addr), 64'(exp_addr));
        checkOutput("valid", 64'(valid), 64'(m_valid));
        if (m_valid) checkOutput("cmd_word", 64'(word), 64'(m_word));
        checkOutput("inc", 64'(inc), 64'(adv_now && adv_kind == 1));
        checkOutput("sel", 64'(sel), 64'(adv_now && adv_kind == 2));
        if (adv_now && adv_kind == 2) checkOutput("sel_value", 64'(sel_value), 64'(adv_target));

        inc_count += int'(inc);
        sel_count += int'(sel);
        valid_cycles += int'(valid);
        req_cycles += int'(req);
        if (req && !req_prev) begin
            fetch_count++;
            if (fetch_count == 1) first_fetch_addr = addr;
            last_fetch_addr = addr;
        end
        req_prev = req;
        if (sel) last_sel_value = sel_value;

        ack = 1'b0;
        done = 1'b0;
        cond = rand_cond ? 1'($urandom_range(0, 1)) : cond_tbl[addr];
        if (force_ack) begin
            ack = 1'b1;
            data = force_data;
        end else if (req) begin
            if (mem_cnt >= mem_wait) begin
                ack = 1'b1;
                data = mem[addr];
                mem_cnt = 0;
                mem_wait = pickWait(mem_wait_cfg);
            end else mem_cnt++;
        end
        if (valid) begin
            if (pu_cnt >= pu_wait) begin
                done = 1'b1;
                pu_cnt = 0;
                pu_wait = pickWait(pu_wait_cfg);
            end else pu_cnt++;
        end else if (spurious_done) done = ($urandom_range(0, 7) == 0);
        if (ack && req) begin
            prev_ack = last_ack;
            last_ack = cyc;
        end

        strt_next = strt;
        if (inc) strt_next = strt + 12'd1;
        if (sel) strt_next = sel_value;

        cur_valid = m_valid;
        if (!resetn) begin
            m_running = 0; m_halted = 0; m_req = 0; m_valid = 0; stop_flag = 0;
            fetch_due = -1; adv_cycle = -1; mem_cnt = 0; pu_cnt = 0;
        end else if (!m_running) begin
            if (start && !stop) begin
                m_running = 1; m_halted = 0; stop_flag = 0;
                exp_addr = strt;
                fetch_due = cyc + 1;
            end
        end else begin
            if (stop) stop_flag = 1;
            if (adv_now) begin
                if (stop_flag || step) m_running = 0;
                else fetch_due = cyc + 2;
            end
            if (ack && m_req) begin
                m_req = 0;
                op = data[WORD_W-1 -: 6];
                if (op == OP_HALT) begin
                    m_running = 0;
                    m_halted = 1;
                end else if (op == OP_JMP || (op == OP_JCND && cond)) begin
                    adv_cycle = cyc + 1; adv_kind = 2;
                    adv_target = data[11:0];
                    exp_addr = data[11:0];
                end else if (op == OP_JCND) begin
                    adv_cycle = cyc + 1; adv_kind = 1;
                    exp_addr = exp_addr + 12'd1;
                end else begin
                    m_valid = 1;
                    m_word = data;
                    exp_addr = exp_addr + 12'd1;
                end
            end
            if (done && cur_valid) begin
                m_valid = 0;
                adv_cycle = cyc + 1; adv_kind = 1;
            end
        end

        @(posedge clk);
        #1;
        strt = strt_next;
        cyc++;
    endtask

    task automatic clearStats();
        inc_count = 0; sel_count = 0; valid_cycles = 0; req_cycles = 0; fetch_count = 0;
        last_ack = 0; prev_ack = 0;
        first_fetch_addr = 0; last_fetch_addr = 0; last_sel_value = 0;
    endtask

    task automatic setWaits(input int mw, input int pw);
        mem_wait_cfg = mw; pu_wait_cfg = pw;
        mem_wait = pickWait(mw); pu_wait = pickWait(pw);
        mem_cnt = 0; pu_cnt = 0;
    endtask

    task automatic pressStart(input logic [11:0] a);
        clearStats();
        strt = a;
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
    endtask

    task automatic runUntilIdle(input int limit);
        int n = 0;
        while (m_running && n < limit) begin
            applyStimulus();
            n++;
        end
        checkOutput("idle_reached", 64'(m_running), 64'd0);
    endtask

    initial begin
        resetn = 0; start = 0; stop = 0; step = 0; strt = 0;
        ack = 0; data = 0; done = 0; cond = 0;
        cyc = 0; fetch_due = -1; adv_cycle = -1; adv_kind = 0;
        m_running = 0; m_halted = 0; m_req = 0; m_valid = 0; stop_flag = 0;
        exp_addr = 0; adv_target = 0; m_word = 0; req_prev = 0;
        checks = 0; passed = 0;
        rand_cond = 0; spurious_done = 0; force_ack = 0; force_data = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = '0;
            cond_tbl[i] = 1'b0;
        end
        setWaits(0, 0);
        clearStats();

        applyStimulus();
        applyStimulus();
        resetn = 1;
        checkOutput("rst_running", 64'(running), 64'd0);
        checkOutput("rst_req", 64'(req), 64'd0);
        checkOutput("rst_valid", 64'(valid), 64'd0);
        checkOutput("rst_strobes", 64'({inc, sel}), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_addr", 64'(addr), 64'd0);
        checkOutput("rst_word", 64'(word), 64'd0);

        // Ordinary command with a slow memory and slow PU, then halt.
        mem[12'o100] = {6'o01, 30'd12345};
        mem[12'o101] = {OP_HALT, 30'd0};
        setWaits(2, 3);
        pressStart(12'o100);
        runUntilIdle(100);
        checkOutput("s1_first_addr", 64'(first_fetch_addr), 64'o100);
        checkOutput("s1_req_cycles", 64'(req_cycles), 64'd6);
        checkOutput("s1_valid_cycles", 64'(valid_cycles), 64'd4);
        checkOutput("s1_inc", 64'(inc_count), 64'd1);
        checkOutput("s1_sel", 64'(sel_count), 64'd0);
        checkOutput("s1_next_addr", 64'(last_fetch_addr), 64'o101);

        // Unconditional jump with zero-wait memory.
        mem[12'o200] = {OP_JMP, 18'd0, 12'o4321};
        mem[12'o4321] = {OP_HALT, 30'd0};
        setWaits(0, 0);
        pressStart(12'o200);
        runUntilIdle(100);
        checkOutput("s2_sel", 64'(sel_count), 64'd1);
        checkOutput("s2_inc", 64'(inc_count), 64'd0);
        checkOutput("s2_valid", 64'(valid_cycles), 64'd0);
        checkOutput("s2_sel_value", 64'(last_sel_value), 64'o4321);
        checkOutput("s2_next_addr", 64'(last_fetch_addr), 64'o4321);
        checkOutput("s2_gap", 64'(last_ack - prev_ack), 64'd3);

        // Conditional jump not taken, then taken.
        mem[12'o400] = {OP_JCND, 18'd0, 12'o777};
        mem[12'o401] = {OP_JCND, 18'd0, 12'o17};
        mem[12'o17] = {OP_HALT, 30'd0};
        cond_tbl[12'o401] = 1'b1;
        pressStart(12'o400);
        runUntilIdle(100);
        checkOutput("s3_inc", 64'(inc_count), 64'd1);
        checkOutput("s3_sel", 64'(sel_count), 64'd1);
        checkOutput("s3_sel_value", 64'(last_sel_value), 64'o17);
        checkOutput("s3_fetches", 64'(fetch_count), 64'd3);
        checkOutput("s3_last_addr", 64'(last_fetch_addr), 64'o17);

        // Halt, then restart at the same address.
        mem[12'o300] = {OP_HALT, 30'd0};
        pressStart(12'o300);
        runUntilIdle(100);
        checkOutput("s4_halted", 64'(halted), 64'd1);
        checkOutput("s4_running", 64'(running), 64'd0);
        checkOutput("s4_strobes", 64'(inc_count + sel_count), 64'd0);
        clearStats();
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        checkOutput("s4_halt_cleared", 64'(halted), 64'd0);
        runUntilIdle(100);
        checkOutput("s4_refetch", 64'(first_fetch_addr), 64'o300);
        checkOutput("s4_halted_again", 64'(halted), 64'd1);

        // Stop during a fetch wait: command still completes with one strobe.
        setWaits(3, 1);
        pressStart(12'o500);
        applyStimulus();
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        runUntilIdle(100);
        checkOutput("s5_fetches", 64'(fetch_count), 64'd1);
        checkOutput("s5_inc", 64'(inc_count), 64'd1);
        checkOutput("s5_strt", 64'(strt), 64'o501);
        checkOutput("s5_halted", 64'(halted), 64'd0);

        // Single-command mode.
        setWaits(1, 0);
        step = 1'b1;
        pressStart(12'o600);
        runUntilIdle(100);
        step = 1'b0;
        checkOutput("s6_fetches", 64'(fetch_count), 64'd1);
        checkOutput("s6_inc", 64'(inc_count), 64'd1);

        // Start together with stop is ignored.
        start = 1'b1;
        stop = 1'b1;
        applyStimulus();
        start = 1'b0;
        stop = 1'b0;
        applyStimulus();
        checkOutput("s7_running", 64'(running), 64'd0);
        checkOutput("s7_req", 64'(req), 64'd0);

        // Reset with a read outstanding; a stale ack follows reset.
        setWaits(10, 0);
        pressStart(12'o700);
        applyStimulus();
        applyStimulus();
        resetn = 1'b0;
        applyStimulus();
        resetn = 1'b1;
        clearStats();
        force_ack = 1'b1;
        force_data = {6'o01, 30'd5};
        applyStimulus();
        force_ack = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("s8_running", 64'(running), 64'd0);
        checkOutput("s8_req", 64'(req), 64'd0);
        checkOutput("s8_valid", 64'(valid_cycles), 64'd0);
        checkOutput("s8_strobes", 64'(inc_count + sel_count), 64'd0);

        // Random programs, waits, conditions and panel activity.
        for (int i = 0; i < 4096; i++) mem[i] = randWord();
        rand_cond = 1'b1;
        spurious_done = 1'b1;
        setWaits(-1, -1);
        for (int n = 0; n < 3000; n++) begin
            if (!m_running) begin
                start = ($urandom_range(0, 3) == 0);
                stop = start && ($urandom_range(0, 7) == 0);
                if (start) strt = 12'($urandom);
            end else begin
                start = ($urandom_range(0, 15) == 0);
                stop = ($urandom_range(0, 39) == 0);
            end
            step = ($urandom_range(0, 19) == 0);
            applyStimulus();
        end
        start = 1'b0;
        step = 1'b0;
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        runUntilIdle(300);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sel_fetch.md
Name: sel_fetch

Overview:
Command-fetch sequencer sitting directly downstream of the start register. It takes the current start-register address and reads the command word from memory with a req/ack handshake. It hands ordinary commands to the PU, resolves jump and halt commands itself, and drives the start register's increment/load strobes and the select value it consumes.

Parameters:
WORD_W, 36, command word width (opcode in [WORD_W-1 -: 6], address field in [11:0])
OP_JMP, 6'o16, unconditional jump opcode
OP_JCND, 6'o17, conditional jump opcode (taken when cond_from_ar=1)
OP_HALT, 6'o77, halt opcode

Ports:
clk  input  1  clock, all state changes on rising edge
resetn  input  1  synchronous reset, active-low
start_from_pnl  input  1  panel start pulse
stop_from_pnl  input  1  panel stop pulse
step_from_pnl  input  1  level, single-command mode
strt_value_from_strt  input  12  current start-register address
mem_rd_req_to_mem  output  1  memory read request
mem_addr_to_mem  output  12  read address, latched
mem_rd_ack_from_mem  input  1  one-cycle read acknowledge, data valid same cycle
mem_data_from_mem  input  WORD_W  read data
cmd_valid_to_pu  output  1  command held for PU execution
cmd_word_to_pu  output  WORD_W  latched command word
cmd_done_from_pu  input  1  PU finished current command (pulse)
cond_from_ar  input  1  jump condition from arithmetic unit
do_inc_strt_to_strt  output  1  one-cycle increment strobe
do_sel_to_strt_to_strt  output  1  one-cycle load strobe
sel_value_to_strt  output  12  jump target (address field of latched word)
running_to_pnl  output  1  sequencer not IDLE
halted_to_pnl  output  1  sticky: stopped on OP_HALT

Behaviour:
- Reset (resetn=0 at edge): state IDLE, all strobes/req/valid 0, mem_addr 0, cmd_word 0, stop_pend 0, halted 0. Reset wins over everything, including mid-handshake; a pending ack after reset is ignored.
- States: IDLE, FETCH, EXEC, ADV.
- IDLE: on start_from_pnl=1 and stop_from_pnl=0 -> FETCH, latch mem_addr<=strt_value_from_strt, clear halted and stop_pend. start together with stop is ignored.
- FETCH: mem_rd_req=1 and mem_addr stable until ack. On ack, cmd_word<=mem_data. Then by opcode:
  - OP_HALT -> IDLE, halted<=1, no strobe.
  - OP_JMP, or OP_JCND with cond_from_ar=1 (sampled in the ack cycle) -> ADV with sel action.
  - OP_JCND not taken -> ADV with inc action.
  - Any other opcode -> EXEC.
- EXEC: cmd_valid=1 until cmd_done_from_pu; done -> ADV with inc action. A done arriving in any other state is ignored.
- ADV: exactly one cycle.
  - do_inc_strt=1 (inc action) or do_sel_to_strt=1 (sel action); never both.
  - sel_value_to_strt = cmd_word[11:0], driven continuously.
  - Next state: IDLE if stop_pend, step_from_pnl, or stop_from_pnl this cycle; otherwise FETCH.
  - FETCH entry from ADV latches mem_addr from strt_value_from_strt on the following edge, i.e. after the start register has updated. Minimum fetch-to-fetch gap for a jump with zero-wait memory: ack cycle + ADV + FETCH entry = 3 cycles.
- stop_from_pnl in FETCH/EXEC sets stop_pend. It never aborts a memory handshake or PU execution; the sequencer stops at the next ADV.
- start_from_pnl outside IDLE is ignored.
- Address wrap-around is handled by the start register (7777o+1=0); the sequencer is transparent to it.
- running_to_pnl = (state != IDLE).

Test Plan:
- Reset, start with strt=0o100, memory word opcode 0o01, ack after 2 wait cycles, PU done after 3 cycles -> mem_addr=0o100; req held 3 cycles; cmd_valid held until done; one do_inc_strt pulse; next fetch at 0o101.
- Word OP_JMP with addr 0o4321 at 0o200 -> no cmd_valid; single do_sel_to_strt pulse with sel_value=0o4321; next mem_addr=0o4321.
- OP_JCND with cond_from_ar=0, then =1 (target 0o17) -> first case gives do_inc_strt; second gives do_sel_to_strt with sel_value=0o17.
- OP_HALT at 0o300 -> returns to IDLE; halted=1, running=0, no strobes; a new start clears halted and refetches 0o300.
- stop_from_pnl during FETCH wait, and separately step_from_pnl=1 -> current command completes with exactly one ADV strobe, then IDLE; start together with stop in IDLE stays IDLE.
- resetn=0 while req outstanding, ack arriving the cycle after reset -> IDLE, req=0, no cmd_valid, no strobe.
